// File: rtl/led_pattern_seq_if.sv
// Mode request handshake between a pattern controller and led_pattern_seq.
interface led_pattern_seq_if;
    logic [1:0] mode;
    logic       mode_valid;
    logic       mode_ready;

    modport master (output mode, output mode_valid, input mode_ready);
    modport slave  (input mode, input mode_valid, output mode_ready);
endinterface

// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: OFF/BLINK/CHASE/BOUNCE patterns advanced every
// STEP_TICKS tick strobes while running; mode changes via a valid/ready handshake.
module led_pattern_seq #(
    parameter int unsigned N_LED      = 4,
    parameter int unsigned STEP_TICKS = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               tick,
    led_pattern_seq_if.slave   mif,
    output logic [N_LED-1:0]   led,
    output logic               step_done
);

    localparam int unsigned   CW       = $clog2(STEP_TICKS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STEP_TICKS - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_t;
    typedef enum logic [1:0] {M_OFF, M_BLINK, M_CHASE, M_BOUNCE} mode_t;

    state_t            state_q, state_d;
    mode_t             mode_q, mode_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [N_LED-1:0]  led_q, led_d;
    logic [N_LED-1:0]  shift_w;
    logic              dir_down_q, dir_down_d;
    logic              step_done_q, step_done_d;
    logic              step_w;
    logic              accept_w;

    function automatic logic [N_LED-1:0] init_pattern(input mode_t m);
        case (m)
            M_OFF:   init_pattern = '0;
            M_BLINK: init_pattern = '1;
            default: init_pattern = N_LED'(1);
        endcase
    endfunction

    // A step cycle blocks the handshake so a tick-driven step and an accept never coincide.
    assign step_w         = (state_q == S_RUN) && tick && (cnt_q == CNT_LAST);
    assign mif.mode_ready = !step_w;
    assign accept_w       = mif.mode_valid && !step_w;

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        cnt_d       = cnt_q;
        led_d       = led_q;
        dir_down_d  = dir_down_q;
        step_done_d = 1'b0;
        shift_w     = dir_down_q ? (led_q >> 1) : (led_q << 1);

        if (accept_w) begin
            mode_d     = mode_t'(mif.mode);
            led_d      = init_pattern(mode_t'(mif.mode));
            cnt_d      = '0;
            dir_down_d = 1'b0;
            if (mode_t'(mif.mode) == M_OFF) state_d = S_IDLE;
            else                            state_d = enable ? S_RUN : S_PAUSE;
        end else begin
            case (state_q)
                S_RUN:   if (!enable) state_d = S_PAUSE;
                S_PAUSE: if (enable)  state_d = S_RUN;
                default: ;
            endcase

            if (state_q == S_RUN && tick) begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d       = '0;
                    step_done_d = 1'b1;
                    case (mode_q)
                        M_BLINK: led_d = ~led_q;
                        M_CHASE: led_d = {led_q[N_LED-2:0], led_q[N_LED-1]};
                        M_BOUNCE: begin
                            led_d = shift_w;
                            // Direction flips on arrival at an end, not on leaving it.
                            if (shift_w[N_LED-1])  dir_down_d = 1'b1;
                            else if (shift_w[0])   dir_down_d = 1'b0;
                        end
                        default: ;
                    endcase
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            mode_q      <= M_OFF;
            cnt_q       <= '0;
            led_q       <= '0;
            dir_down_q  <= 1'b0;
            step_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            cnt_q       <= cnt_d;
            led_q       <= led_d;
            dir_down_q  <= dir_down_d;
            step_done_q <= step_done_d;
        end
    end

    assign led       = led_q;
    assign step_done = step_done_q;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Directed bench for led_pattern_seq (N_LED=4, STEP_TICKS=4).
module tb_led_pattern_seq;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       tick = 1'b0;
    logic [3:0] led;
    logic       step_done;
    int         total = 0;
    int         bad = 0;

    led_pattern_seq_if mif ();

    led_pattern_seq #(.N_LED(4), .STEP_TICKS(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .tick      (tick),
        .mif       (mif.slave),
        .led       (led),
        .step_done (step_done)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [1:0] m);
        mif.mode = m;
        mif.mode_valid = 1'b1;
        cycle();
        mif.mode_valid = 1'b0;
    endtask

    task automatic tick_once();
        tick = 1'b1;
        cycle();
        tick = 1'b0;
    endtask

    task automatic test_reset();
        mif.mode = 2'd2;
        mif.mode_valid = 1'b1;
        reset = 1'b0;
        repeat (3) cycle();
        total++;
        if (led !== 4'b0000) begin bad++; $display("FAIL reset_hold_led got=%b exp=0000", led); end
        mif.mode_valid = 1'b0;
        reset = 1'b1;
        cycle();
        total++;
        if (led !== 4'b0000) begin bad++; $display("FAIL reset_led got=%b exp=0000", led); end
        total++;
        if (step_done !== 1'b0) begin bad++; $display("FAIL reset_step_done got=%b exp=0", step_done); end
        total++;
        if (mif.mode_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", mif.mode_ready); end
    endtask

    task automatic test_blink();
        logic [3:0] exp_led;
        int pulses = 0;
        enable = 1'b1;
        accept(2'd1);
        total++;
        if (led !== 4'b1111) begin bad++; $display("FAIL blink_init got=%b exp=1111", led); end
        for (int i = 1; i <= 8; i++) begin
            tick_once();
            exp_led = (i >= 4 && i < 8) ? 4'b0000 : 4'b1111;
            total++;
            if (led !== exp_led) begin bad++; $display("FAIL blink_led tick=%0d got=%b exp=%b", i, led, exp_led); end
            total++;
            if (step_done !== (i % 4 == 0)) begin
                bad++; $display("FAIL blink_step_done tick=%0d got=%b exp=%b", i, step_done, (i % 4 == 0));
            end
            if (step_done === 1'b1) pulses++;
        end
        total++;
        if (pulses !== 2) begin bad++; $display("FAIL blink_pulses got=%0d exp=2", pulses); end
    endtask

    task automatic test_chase();
        logic [3:0] exp_tab [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        enable = 1'b1;
        accept(2'd2);
        total++;
        if (led !== 4'b0001) begin bad++; $display("FAIL chase_init got=%b exp=0001", led); end
        for (int i = 1; i <= 16; i++) begin
            tick_once();
            if (i % 4 == 0) begin
                total++;
                if (led !== exp_tab[i/4-1]) begin
                    bad++; $display("FAIL chase_led tick=%0d got=%b exp=%b", i, led, exp_tab[i/4-1]);
                end
            end
        end
    endtask

    task automatic test_bounce();
        logic [3:0] exp_tab [7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
        enable = 1'b1;
        accept(2'd3);
        total++;
        if (led !== 4'b0001) begin bad++; $display("FAIL bounce_init got=%b exp=0001", led); end
        for (int i = 1; i <= 28; i++) begin
            tick_once();
            total++;
            if ($countones(led) != 1) begin bad++; $display("FAIL bounce_onehot tick=%0d got=%b exp=one-hot", i, led); end
            if (i % 4 == 0) begin
                total++;
                if (led !== exp_tab[i/4-1]) begin
                    bad++; $display("FAIL bounce_led tick=%0d got=%b exp=%b", i, led, exp_tab[i/4-1]);
                end
            end
        end
    endtask

    task automatic test_collision();
        enable = 1'b1;
        accept(2'd2);
        repeat (3) tick_once();
        tick = 1'b1;
        mif.mode = 2'd3;
        mif.mode_valid = 1'b1;
        #1;
        total++;
        if (mif.mode_ready !== 1'b0) begin bad++; $display("FAIL coll_ready_step got=%b exp=0", mif.mode_ready); end
        cycle();
        total++;
        if (led !== 4'b0010 || step_done !== 1'b1) begin
            bad++; $display("FAIL coll_step got=%b/%b exp=0010/1", led, step_done);
        end
        total++;
        if (mif.mode_ready !== 1'b1) begin bad++; $display("FAIL coll_ready_next got=%b exp=1", mif.mode_ready); end
        cycle();
        mif.mode_valid = 1'b0;
        tick = 1'b0;
        total++;
        if (led !== 4'b0001 || step_done !== 1'b0) begin
            bad++; $display("FAIL coll_accept got=%b/%b exp=0001/0", led, step_done);
        end
        repeat (3) tick_once();
        total++;
        if (led !== 4'b0001) begin bad++; $display("FAIL coll_tick_discard got=%b exp=0001", led); end
        tick_once();
        total++;
        if (led !== 4'b0010 || step_done !== 1'b1) begin
            bad++; $display("FAIL coll_first_step got=%b/%b exp=0010/1", led, step_done);
        end
    endtask

    task automatic test_pause_reset();
        enable = 1'b1;
        accept(2'd2);
        repeat (2) tick_once();
        enable = 1'b0;
        cycle();
        for (int i = 0; i < 5; i++) begin
            tick_once();
            total++;
            if (led !== 4'b0001 || step_done !== 1'b0) begin
                bad++; $display("FAIL pause_hold tick=%0d got=%b/%b exp=0001/0", i, led, step_done);
            end
        end
        enable = 1'b1;
        cycle();
        tick_once();
        total++;
        if (led !== 4'b0001) begin bad++; $display("FAIL resume_mid got=%b exp=0001", led); end
        tick_once();
        total++;
        if (led !== 4'b0010 || step_done !== 1'b1) begin
            bad++; $display("FAIL resume_step got=%b/%b exp=0010/1", led, step_done);
        end
        tick_once();
        #2;
        reset = 1'b0;
        #1;
        total++;
        if (led !== 4'b0000) begin bad++; $display("FAIL async_reset got=%b exp=0000", led); end
        cycle();
        reset = 1'b1;
        for (int i = 0; i < 6; i++) tick_once();
        total++;
        if (led !== 4'b0000 || step_done !== 1'b0) begin
            bad++; $display("FAIL idle_after_reset got=%b/%b exp=0000/0", led, step_done);
        end
    endtask

    task automatic test_pause_accept_off();
        enable = 1'b0;
        accept(2'd1);
        total++;
        if (led !== 4'b1111) begin bad++; $display("FAIL pause_accept got=%b exp=1111", led); end
        for (int i = 0; i < 8; i++) tick_once();
        total++;
        if (led !== 4'b1111) begin bad++; $display("FAIL pause_accept_hold got=%b exp=1111", led); end
        enable = 1'b1;
        accept(2'd2);
        repeat (4) tick_once();
        accept(2'd2);
        total++;
        if (led !== 4'b0001) begin bad++; $display("FAIL reaccept_restart got=%b exp=0001", led); end
        accept(2'd0);
        total++;
        if (led !== 4'b0000) begin bad++; $display("FAIL off_accept got=%b exp=0000", led); end
        repeat (4) tick_once();
        total++;
        if (led !== 4'b0000 || step_done !== 1'b0) begin
            bad++; $display("FAIL off_hold got=%b/%b exp=0000/0", led, step_done);
        end
    endtask

    initial begin
        mif.mode = 2'd0;
        mif.mode_valid = 1'b0;
        test_reset();
        test_blink();
        test_chase();
        test_bounce();
        test_collision();
        test_pause_reset();
        test_pause_accept_off();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_pattern_seq.md
LED_PATTERN_SEQ -- requirements
Module: led_pattern_seq

Interface
REQ-001 Parameter N_LED, default 4: number of LED outputs, minimum 2.
REQ-002 Parameter STEP_TICKS, default 4: tick pulses per pattern step, minimum 1.
REQ-003 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-low reset; 0 resets immediately, independent of clk.
REQ-005 Port enable, input, 1: 1 = run, 0 = pause.
REQ-006 Port tick, input, 1: one-cycle strobe from the upstream count stage.
REQ-007 Port mode, input, 2: requested pattern; 0 OFF, 1 BLINK, 2 CHASE, 3 BOUNCE.
REQ-008 Port mode_valid, input, 1: mode holds a request.
REQ-009 Port mode_ready, output, 1: block can accept a mode request this cycle.
REQ-010 Port led, output, N_LED: registered LED drive; bit 0 is LED0.
REQ-011 Port step_done, output, 1: registered one-cycle pulse on each pattern step.

Function
REQ-012 FSM states: IDLE (mode OFF), RUN (enable=1, mode not OFF), PAUSE (enable=0, mode not OFF).
REQ-013 Transitions: RUN->PAUSE and PAUSE->RUN follow enable on the next edge; any state->IDLE on accepting mode 0; IDLE->RUN or PAUSE (per enable) on accepting modes 1-3.
REQ-014 Accept condition: a mode request is accepted when mode_valid=1 and mode_ready=1 at a rising edge.
REQ-015 mode_ready: combinational; it is 0 only in a step cycle (REQ-017) and 1 otherwise, including in PAUSE and IDLE.
REQ-016 Tick counter: width ceil(log2(STEP_TICKS+1)), range 0..STEP_TICKS-1; increments on tick=1 in RUN only.
REQ-017 Step cycle: state RUN, tick=1 and counter=STEP_TICKS-1. On the next edge the counter wraps to 0, led advances one step and step_done=1.
REQ-018 step_done is 0 in every cycle that does not follow a step cycle.
REQ-019 BLINK: the initial pattern is all ones; each step inverts every led bit.
REQ-020 CHASE: the initial pattern is one-hot bit 0; each step rotates left, and bit N_LED-1 wraps to bit 0.
REQ-021 BOUNCE: the initial pattern is one-hot bit 0 with direction up.
REQ-022 BOUNCE stepping: each step shifts one position in the current direction; reaching bit N_LED-1 sets direction down, and reaching bit 0 sets direction up. For N_LED=4 the period is 6 steps: 0001,0010,0100,1000,0100,0010,0001.
REQ-023 Mode accept: on the next edge the block loads the mode's initial pattern into led (OFF loads all zeros), clears the counter and sets direction up.
REQ-024 Re-accepting the current mode also restarts its pattern.
REQ-025 If a tick coincides with a mode accept, the mode accept takes priority and the tick is discarded.
REQ-026 In PAUSE and IDLE, tick is ignored, and led and counter hold.
REQ-027 On PAUSE->RUN, counting resumes from the held counter value.
REQ-028 In IDLE, led stays all zeros.
REQ-029 enable does not gate mode accepts.

Reset
REQ-030 While reset=0: state IDLE, led=0, counter=0, direction up, step_done=0, mode_valid ignored.
REQ-031 Reset applied mid-step or mid-pattern discards all progress; after release the block waits in IDLE for a new mode request.
REQ-032 The first rising edge after reset rises to 1 follows the normal rules.

Verification
REQ-033 Reset sequence: hold reset=0 for 3 cycles, then release, with no mode request -> led=0000, step_done=0, mode_ready=1.
REQ-034 BLINK: accept mode 1 with enable=1, then apply 8 ticks (STEP_TICKS=4) -> led=1111, then 0000 after tick 4, then 1111 after tick 8; two step_done pulses.
REQ-035 CHASE wrap: accept mode 2, then 16 ticks -> led=0010, 0100, 1000, 0001.
REQ-036 BOUNCE reversal: accept mode 3, then 28 ticks -> led=0010, 0100, 1000, 0100, 0010, 0001, 0010; no 2-bit pattern ever appears.
REQ-037 Handshake collision: mode_valid held high across a step cycle -> mode_ready=0 in that cycle; the request is accepted the next cycle; a tick coincident with the accept is discarded.
REQ-038 Pause and reset: enable=0 after 2 ticks of CHASE, then 5 ticks -> led holds; enable=1, then 2 ticks -> a step occurs; reset=0 mid-sequence -> led=0000 asynchronously.
